reservoir_epoch_controller: RTL and testbench
=============================================

Name: reservoir_epoch_controller

Overview:
Sequences one reservoir epoch per NARMA sample for the LIF ring. Per sample: fetches a 32-bit input bitstream via valid/ready, drives it as ext_input for a fixed window, and holds a zero-input settle window. It counts spikes per neuron during both windows, then streams the per-neuron spike counts to the readout over a valid/ready port. Sits between the bitstream converter, the neuron array and the readout/trainer.

Parameters:
N_NEURONS, 10, number of reservoir neurons (spike inputs, counters)
DRIVE_CYCLES, 8, clocks ext_input holds the latched sample
SETTLE_CYCLES, 4, clocks of zero input after drive
CNT_W, 8, spike counter width
NUM_SAMPLES, 200, samples per epoch run
TIMEOUT, 64, FETCH watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous, active-low reset
start  in  1  begin run (sampled in IDLE)
stop  in  1  synchronous abort, any state
sample_in  in  32  bitstream from converter
sample_valid  in  1  sample_in valid
sample_ready  out  1  controller accepts sample
ext_input  out  32  drive to every neuron ext_input
neuron_en  out  1  neurons integrating
spikes_in  in  N_NEURONS  spike bit per neuron
rd_valid  out  1  readout word valid
rd_ready  in  1  readout accepts
rd_idx  out  clog2(N_NEURONS)  neuron index of rd_count
rd_count  out  CNT_W  spike count of neuron rd_idx
sample_cnt  out  16  samples completed this run
busy  out  1  state != IDLE
epoch_done  out  1  one-cycle pulse, run finished
err  out  1  one-cycle pulse, FETCH timeout (0 without feature)

Behaviour:
- Reset (rst==0 at posedge, any state): next state IDLE. Outputs ext_input, neuron_en, sample_ready, rd_valid, rd_idx, rd_count, sample_cnt, busy, epoch_done, err all 0. Spike counters cleared.
- States: IDLE, FETCH, DRIVE, SETTLE, READOUT.
- IDLE: start=1 -> FETCH; sample_cnt cleared.
- stop=1 in any non-reset cycle -> IDLE next cycle. ext_input=0, no epoch_done, sample_cnt retained. stop beats start. rst beats stop.
- FETCH: sample_ready=1 (registered, asserted the cycle FETCH is entered). Handshake sample_valid&sample_ready latches sample_in, clears all spike counters, moves to DRIVE. ext_input shows the sample from the first DRIVE cycle.
- DRIVE: neuron_en=1, ext_input=latched sample, exactly DRIVE_CYCLES cycles, then SETTLE.
- SETTLE: neuron_en=1, ext_input=0, exactly SETTLE_CYCLES cycles, then READOUT with rd_idx=0.
- Spike counting only in DRIVE and SETTLE:
  - counter[i] += spikes_in[i] each cycle.
  - Saturates at 2^CNT_W-1, no wrap.
  - spikes_in ignored in all other states.
- READOUT:
  - neuron_en=0, ext_input=0, rd_valid=1, rd_count=counter[rd_idx].
  - rd_valid, rd_idx and rd_count are held stable while rd_ready=0.
  - Each rd_valid&rd_ready increments rd_idx.
  - When index N_NEURONS-1 is accepted: sample_cnt+=1. If the new sample_cnt == NUM_SAMPLES -> IDLE with epoch_done=1 for that one cycle; otherwise -> FETCH.
- Latency: handshake to first ext_input cycle = 1 clock. Handshake to first rd_valid = DRIVE_CYCLES+SETTLE_CYCLES+1 clocks.
- All outputs registered. No combinational path from inputs to outputs.

Optional Feature:
Macro RESERVOIR_FETCH_TIMEOUT_EN.
- Defined: a counter runs in FETCH and clears on entering FETCH. If TIMEOUT consecutive FETCH cycles pass without a handshake: err=1 for one cycle, state -> IDLE, no epoch_done.
- Undefined: FETCH waits indefinitely and err is tied 0.

Test Plan:
1. Single sample (NUM_SAMPLES=1): sample_in=0xA5A5A5A5 with valid; spikes_in[3]=1 for all 12 DRIVE+SETTLE cycles, others 0 -> ext_input=0xA5A5A5A5 for exactly 8 cycles then 0. Readout idx0..9 gives counts 0,0,0,12,0,0,0,0,0,0. epoch_done pulses once, sample_cnt=1, busy falls.
2. Saturation (CNT_W=3): spikes_in all 1s through DRIVE+SETTLE -> every rd_count=7.
3. Backpressure: rd_ready=0 for 5 cycles at rd_idx=4 -> rd_valid=1, rd_idx=4, rd_count unchanged throughout. Resumes at idx5 after rd_ready=1.
4. Multi-sample (NUM_SAMPLES=3): back-to-back samples -> FETCH re-entered twice, sample_cnt 1,2,3. Counters cleared per sample. Single epoch_done after third readout.
5. Abort/reset: stop=1 in SETTLE cycle 2 -> IDLE next cycle, ext_input=0, no epoch_done. Separately, rst=0 mid-DRIVE -> all outputs 0 next cycle; start after release runs normally.
6. With RESERVOIR_FETCH_TIMEOUT_EN, TIMEOUT=16, sample_valid held 0 -> err pulses after 16 FETCH cycles, state IDLE. Without the macro, the same stimulus keeps the controller in FETCH and err stays 0.

Source files
------------

// File: rtl/reservoir_epoch_controller.sv
// Reservoir epoch sequencer: fetch sample, drive, settle, then stream per-neuron spike counts.
// Optional FETCH watchdog compiled in with `define RESERVOIR_FETCH_TIMEOUT_EN.
module reservoir_epoch_controller #(
    parameter int N_NEURONS     = 10,
    parameter int DRIVE_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter int NUM_SAMPLES   = 200,
    parameter int TIMEOUT       = 64,
    localparam int IDX_W        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [31:0]          sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic [31:0]          ext_input,
    output logic                 neuron_en,
    input  logic [N_NEURONS-1:0] spikes_in,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [IDX_W-1:0]     rd_idx,
    output logic [CNT_W-1:0]     rd_count,
    output logic [15:0]          sample_cnt,
    output logic                 busy,
    output logic                 epoch_done,
    output logic                 err
);

    localparam int PH_MAX = (DRIVE_CYCLES > SETTLE_CYCLES) ? DRIVE_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (N_NEURONS < 1 || DRIVE_CYCLES < 1 || SETTLE_CYCLES < 1 || CNT_W < 1 ||
        NUM_SAMPLES < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("reservoir_epoch_controller: size parameters must all be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRIVE,
        SETTLE,
        READOUT
    } state_t;

    state_t            state_q;
    logic [PH_W-1:0]   phase_q;
    logic              sampleReady_q;
    logic [31:0]       extInput_q;
    logic              neuronEn_q;
    logic              rdValid_q;
    logic [IDX_W-1:0]  rdIdx_q;
    logic [CNT_W-1:0]  rdCount_q;
    logic [15:0]       sampleCnt_q;
    logic              busy_q;
    logic              epochDone_q;
    logic              err_q;

    logic [CNT_W-1:0]  spikeCnt_q [N_NEURONS];
    logic [CNT_W-1:0]  spikeCnt_d [N_NEURONS];

    logic              countEn;
    logic              fetchAccept;
    logic [IDX_W-1:0]  rdIdxInc;
    logic [15:0]       sampleCntInc;

`ifdef RESERVOIR_FETCH_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0]   fetchTimer_q;
`endif

    assign countEn      = (state_q == DRIVE) || (state_q == SETTLE);
    assign fetchAccept  = (state_q == FETCH) && sample_valid && sampleReady_q;
    assign rdIdxInc     = rdIdx_q + IDX_W'(1);
    assign sampleCntInc = sampleCnt_q + 16'd1;

    // Saturating per-neuron increment; the readout loads from this so the last SETTLE spike is included.
    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            spikeCnt_d[i] = spikeCnt_q[i];
            if (countEn && spikes_in[i] && (spikeCnt_q[i] != CNT_MAX)) begin
                spikeCnt_d[i] = spikeCnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (!rst || fetchAccept) begin
                spikeCnt_q[i] <= '0;
            end else begin
                spikeCnt_q[i] <= spikeCnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            sampleReady_q <= 1'b0;
            extInput_q    <= '0;
            neuronEn_q    <= 1'b0;
            rdValid_q     <= 1'b0;
            rdIdx_q       <= '0;
            rdCount_q     <= '0;
            sampleCnt_q   <= '0;
            busy_q        <= 1'b0;
            epochDone_q   <= 1'b0;
            err_q         <= 1'b0;
`ifdef RESERVOIR_FETCH_TIMEOUT_EN
            fetchTimer_q  <= '0;
`endif
        end else begin
            epochDone_q <= 1'b0;
            err_q       <= 1'b0;
            // Abort keeps sample_cnt so software can see how far the run got.
            if (stop) begin
                state_q       <= IDLE;
                phase_q       <= '0;
                sampleReady_q <= 1'b0;
                extInput_q    <= '0;
                neuronEn_q    <= 1'b0;
                rdValid_q     <= 1'b0;
                rdIdx_q       <= '0;
                rdCount_q     <= '0;
                busy_q        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q       <= FETCH;
                            sampleCnt_q   <= '0;
                            sampleReady_q <= 1'b1;
                            busy_q        <= 1'b1;
`ifdef RESERVOIR_FETCH_TIMEOUT_EN
                            fetchTimer_q  <= '0;
`endif
                        end
                    end
                    FETCH: begin
                        if (fetchAccept) begin
                            state_q       <= DRIVE;
                            sampleReady_q <= 1'b0;
                            extInput_q    <= sample_in;
                            neuronEn_q    <= 1'b1;
                            phase_q       <= '0;
                        end
`ifdef RESERVOIR_FETCH_TIMEOUT_EN
                        else if (fetchTimer_q == TO_W'(TIMEOUT - 1)) begin
                            state_q       <= IDLE;
                            sampleReady_q <= 1'b0;
                            busy_q        <= 1'b0;
                            err_q         <= 1'b1;
                        end else begin
                            fetchTimer_q  <= fetchTimer_q + TO_W'(1);
                        end
`endif
                    end
                    DRIVE: begin
                        if (phase_q == PH_W'(DRIVE_CYCLES - 1)) begin
                            state_q    <= SETTLE;
                            extInput_q <= '0;
                            phase_q    <= '0;
                        end else begin
                            phase_q    <= phase_q + PH_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
                            state_q    <= READOUT;
                            neuronEn_q <= 1'b0;
                            rdValid_q  <= 1'b1;
                            rdIdx_q    <= '0;
                            rdCount_q  <= spikeCnt_d[0];
                        end else begin
                            phase_q    <= phase_q + PH_W'(1);
                        end
                    end
                    READOUT: begin
                        if (rd_ready) begin
                            if (rdIdx_q == IDX_W'(N_NEURONS - 1)) begin
                                rdValid_q   <= 1'b0;
                                rdIdx_q     <= '0;
                                rdCount_q   <= '0;
                                sampleCnt_q <= sampleCntInc;
                                if (sampleCntInc == 16'(NUM_SAMPLES)) begin
                                    state_q     <= IDLE;
                                    busy_q      <= 1'b0;
                                    epochDone_q <= 1'b1;
                                end else begin
                                    state_q       <= FETCH;
                                    sampleReady_q <= 1'b1;
`ifdef RESERVOIR_FETCH_TIMEOUT_EN
                                    fetchTimer_q  <= '0;
`endif
                                end
                            end else begin
                                rdIdx_q   <= rdIdxInc;
                                rdCount_q <= spikeCnt_d[rdIdxInc];
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sample_ready = sampleReady_q;
    assign ext_input    = extInput_q;
    assign neuron_en    = neuronEn_q;
    assign rd_valid     = rdValid_q;
    assign rd_idx       = rdIdx_q;
    assign rd_count     = rdCount_q;
    assign sample_cnt   = sampleCnt_q;
    assign busy         = busy_q;
    assign epoch_done   = epochDone_q;
    assign err          = err_q;

endmodule

// File: tb/tb_reservoir_epoch_controller.sv
// Bench for reservoir_epoch_controller: two instances (8-bit and 3-bit counters) driven in lockstep.
// Expectations for err depend on whether RESERVOIR_FETCH_TIMEOUT_EN is defined.
module tb_reservoir_epoch_controller;

    localparam int N   = 10;
    localparam int DRV = 8;
    localparam int STL = 4;
    localparam int NS  = 3;
    localparam int TMO = 16;
    localparam int IW  = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sampleValid = 1'b0;
    logic          rdReady = 1'b0;
    logic [31:0]   sampleIn = '0;
    logic [N-1:0]  spikesIn = '0;

    logic          aSampleReady, aNeuronEn, aRdValid, aBusy, aEpochDone, aErr;
    logic [31:0]   aExtInput;
    logic [IW-1:0] aRdIdx;
    logic [7:0]    aRdCount;
    logic [15:0]   aSampleCnt;

    logic          bSampleReady, bNeuronEn, bRdValid, bBusy, bEpochDone, bErr;
    logic [31:0]   bExtInput;
    logic [IW-1:0] bRdIdx;
    logic [2:0]    bRdCount;
    logic [15:0]   bSampleCnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]  data;
        logic [N-1:0] mask;
        int           stallIdx;
        int           stallLen;
        int           expHotA;
        int           expHotB;
    } vec_t;

    vec_t vecs[3];

    always #5 clk = ~clk;

    reservoir_epoch_controller #(
        .N_NEURONS(N), .DRIVE_CYCLES(DRV), .SETTLE_CYCLES(STL),
        .CNT_W(8), .NUM_SAMPLES(NS), .TIMEOUT(TMO)
    ) dutA (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .sample_in(sampleIn), .sample_valid(sampleValid), .sample_ready(aSampleReady),
        .ext_input(aExtInput), .neuron_en(aNeuronEn), .spikes_in(spikesIn),
        .rd_valid(aRdValid), .rd_ready(rdReady), .rd_idx(aRdIdx), .rd_count(aRdCount),
        .sample_cnt(aSampleCnt), .busy(aBusy), .epoch_done(aEpochDone), .err(aErr)
    );

    reservoir_epoch_controller #(
        .N_NEURONS(N), .DRIVE_CYCLES(DRV), .SETTLE_CYCLES(STL),
        .CNT_W(3), .NUM_SAMPLES(NS), .TIMEOUT(TMO)
    ) dutB (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .sample_in(sampleIn), .sample_valid(sampleValid), .sample_ready(bSampleReady),
        .ext_input(bExtInput), .neuron_en(bNeuronEn), .spikes_in(spikesIn),
        .rd_valid(bRdValid), .rd_ready(rdReady), .rd_idx(bRdIdx), .rd_count(bRdCount),
        .sample_cnt(bSampleCnt), .busy(bBusy), .epoch_done(bEpochDone), .err(bErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("run busy", 32'(aBusy), 1);
        checkOutput("run sample_ready", 32'(aSampleReady), 1);
        checkOutput("run sample_cnt cleared", 32'(aSampleCnt), 0);
    endtask

    task automatic handshake(input logic [31:0] data);
        checkOutput("fetch sample_ready", 32'(aSampleReady), 1);
        checkOutput("fetch busy", 32'(aBusy), 1);
        sampleIn    = data;
        sampleValid = 1'b1;
        spikesIn    = N'($urandom);
        tick();
        sampleValid = 1'b0;
        sampleIn    = $urandom;
    endtask

    // One full sample: fetch, 12 counting cycles, readout with optional stalls.
    task automatic applyStimulus(input logic [31:0] data, input logic [N-1:0] mask, input bit randomSpikes,
                                 input int stallIdx, input int stallLen, input int expHotA,
                                 input int expHotB, input int expCnt);
        int sums[N];
        int preDelay;
        int stall;
        int expA;
        int expB;
        logic [N-1:0] sp;
        for (int i = 0; i < N; i++) sums[i] = 0;
        preDelay = randomSpikes ? int'($urandom_range(0, 3)) : 0;
        for (int d = 0; d < preDelay; d++) begin
            checkOutput("fetch wait ready", 32'(aSampleReady), 1);
            spikesIn = N'($urandom);
            sampleIn = $urandom;
            tick();
        end
        handshake(data);
        for (int k = 0; k < DRV + STL; k++) begin
            checkOutput("ext_input", aExtInput, (k < DRV) ? data : 32'h0);
            checkOutput("neuron_en", 32'(aNeuronEn), 1);
            checkOutput("sample_ready low", 32'(aSampleReady), 0);
            checkOutput("rd_valid early", 32'(aRdValid), 0);
            sp = randomSpikes ? N'($urandom) : mask;
            spikesIn = sp;
            for (int i = 0; i < N; i++) if (sp[i]) sums[i]++;
            tick();
        end
        for (int idx = 0; idx < N; idx++) begin
            expA  = randomSpikes ? sat(sums[idx], 255) : (mask[idx] ? expHotA : 0);
            expB  = randomSpikes ? sat(sums[idx], 7)   : (mask[idx] ? expHotB : 0);
            stall = (idx == stallIdx) ? stallLen : (randomSpikes ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= stall; s++) begin
                rdReady  = (s == stall);
                spikesIn = N'($urandom);
                checkOutput("rd_valid", 32'(aRdValid), 1);
                checkOutput("rd_idx", 32'(aRdIdx), idx);
                checkOutput("rd_count", 32'(aRdCount), expA);
                checkOutput("rd_valid sat", 32'(bRdValid), 1);
                checkOutput("rd_idx sat", 32'(bRdIdx), idx);
                checkOutput("rd_count sat", 32'(bRdCount), expB);
                checkOutput("readout ext_input", aExtInput, 0);
                checkOutput("readout neuron_en", 32'(aNeuronEn), 0);
                tick();
            end
        end
        rdReady = 1'b0;
        checkOutput("sample_cnt", 32'(aSampleCnt), expCnt);
        checkOutput("rd_valid after readout", 32'(aRdValid), 0);
        if (expCnt == NS) begin
            checkOutput("epoch_done", 32'(aEpochDone), 1);
            checkOutput("epoch_done sat", 32'(bEpochDone), 1);
            checkOutput("busy at end", 32'(aBusy), 0);
            tick();
            checkOutput("epoch_done one cycle", 32'(aEpochDone), 0);
            checkOutput("idle sample_ready", 32'(aSampleReady), 0);
        end else begin
            checkOutput("no early epoch_done", 32'(aEpochDone), 0);
            checkOutput("refetch sample_ready", 32'(aSampleReady), 1);
            checkOutput("refetch busy", 32'(aBusy), 1);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " sample_ready"}, 32'(aSampleReady), 0);
        checkOutput({tag, " ext_input"}, aExtInput, 0);
        checkOutput({tag, " neuron_en"}, 32'(aNeuronEn), 0);
        checkOutput({tag, " rd_valid"}, 32'(aRdValid), 0);
        checkOutput({tag, " rd_idx"}, 32'(aRdIdx), 0);
        checkOutput({tag, " rd_count"}, 32'(aRdCount), 0);
        checkOutput({tag, " sample_cnt"}, 32'(aSampleCnt), 0);
        checkOutput({tag, " busy"}, 32'(aBusy), 0);
        checkOutput({tag, " epoch_done"}, 32'(aEpochDone), 0);
        checkOutput({tag, " err"}, 32'(aErr), 0);
        checkOutput({tag, " sat sample_ready"}, 32'(bSampleReady), 0);
        checkOutput({tag, " sat ext_input"}, bExtInput, 0);
        checkOutput({tag, " sat neuron_en"}, 32'(bNeuronEn), 0);
        checkOutput({tag, " sat rd_valid"}, 32'(bRdValid), 0);
        checkOutput({tag, " sat rd_idx"}, 32'(bRdIdx), 0);
        checkOutput({tag, " sat rd_count"}, 32'(bRdCount), 0);
        checkOutput({tag, " sat sample_cnt"}, 32'(bSampleCnt), 0);
        checkOutput({tag, " sat busy"}, 32'(bBusy), 0);
        checkOutput({tag, " sat epoch_done"}, 32'(bEpochDone), 0);
        checkOutput({tag, " sat err"}, 32'(bErr), 0);
    endtask

    initial begin
        logic [31:0] data;
        vecs[0] = '{32'hA5A5_A5A5, 10'b00_0000_1000, -1, 0, 12, 7};
        vecs[1] = '{32'h1234_5678, 10'b11_1111_1111,  4, 5, 12, 7};
        vecs[2] = '{32'h0F0F_3C3C, 10'b10_0000_0001,  9, 2, 12, 7};

        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b1;
        tick();

        startRun();
        for (int r = 0; r < 3; r++) begin
            applyStimulus(vecs[r].data, vecs[r].mask, 1'b0, vecs[r].stallIdx, vecs[r].stallLen,
                          vecs[r].expHotA, vecs[r].expHotB, r + 1);
        end

        // Abort in the second SETTLE cycle of the second sample.
        startRun();
        applyStimulus($urandom, '0, 1'b1, -1, 0, 0, 0, 1);
        handshake($urandom);
        repeat (DRV + 1) begin
            spikesIn = N'($urandom);
            tick();
        end
        checkOutput("settle ext_input", aExtInput, 0);
        checkOutput("settle neuron_en", 32'(aNeuronEn), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop busy", 32'(aBusy), 0);
        checkOutput("stop ext_input", aExtInput, 0);
        checkOutput("stop neuron_en", 32'(aNeuronEn), 0);
        checkOutput("stop rd_valid", 32'(aRdValid), 0);
        checkOutput("stop sample_cnt kept", 32'(aSampleCnt), 1);
        for (int c = 0; c < 3; c++) begin
            checkOutput("stop no epoch_done", 32'(aEpochDone), 0);
            tick();
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("stop beats start busy", 32'(aBusy), 0);
        checkOutput("stop beats start ready", 32'(aSampleReady), 0);

        // Reset in the middle of DRIVE, then a clean random run.
        startRun();
        applyStimulus($urandom, '0, 1'b1, -1, 0, 0, 0, 1);
        data = $urandom;
        handshake(data);
        repeat (3) tick();
        checkOutput("mid drive ext_input", aExtInput, data);
        rst = 1'b0;
        tick();
        checkAllZero("mid drive reset");
        rst = 1'b1;
        tick();
        startRun();
        for (int s = 1; s <= NS; s++) begin
            applyStimulus($urandom, '0, 1'b1, -1, 0, 0, 0, s);
        end

        // FETCH with sample_valid held low.
        startRun();
        for (int c = 1; c < TMO; c++) begin
            checkOutput("fetch wait err", 32'(aErr), 0);
            checkOutput("fetch wait busy", 32'(aBusy), 1);
            tick();
        end
        checkOutput("last fetch err", 32'(aErr), 0);
        checkOutput("last fetch busy", 32'(aBusy), 1);
        tick();
`ifdef RESERVOIR_FETCH_TIMEOUT_EN
        checkOutput("timeout err", 32'(aErr), 1);
        checkOutput("timeout busy", 32'(aBusy), 0);
        checkOutput("timeout sample_ready", 32'(aSampleReady), 0);
        checkOutput("timeout epoch_done", 32'(aEpochDone), 0);
        tick();
        checkOutput("timeout err pulse", 32'(aErr), 0);
        checkOutput("timeout stays idle", 32'(aBusy), 0);
`else
        checkOutput("no watchdog err", 32'(aErr), 0);
        checkOutput("no watchdog busy", 32'(aBusy), 1);
        checkOutput("no watchdog ready", 32'(aSampleReady), 1);
        repeat (TMO) tick();
        checkOutput("no watchdog err later", 32'(aErr), 0);
        checkOutput("no watchdog still fetch", 32'(aSampleReady), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("no watchdog stopped", 32'(aBusy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] time limit");
    end

endmodule
